// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter:
// mode codes, FSM states and the one-bit step.
package shifter_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    MODE_LSL  = 3'b000,
    MODE_LSR  = 3'b001,
    MODE_ASR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_RCL  = 3'b101,
    MODE_RCR  = 3'b110,
    MODE_PASS = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Returns {cf', r'} packed into bits [w:0]; upper bits are zero.
  function automatic logic [MAX_W:0] shift_step(
    input mode_e            m,
    input logic [MAX_W-1:0] r,
    input logic             cf,
    input int               w
  );
    logic [MAX_W:0] x;
    logic [MAX_W:0] top;
    logic [MAX_W:0] mask;
    logic [MAX_W:0] nr;
    logic           msb;
    logic           lsb;
    logic           ncf;
    x    = {1'b0, r};
    top  = (MAX_W+1)'(1) << (w - 1);
    mask = (top << 1) - (MAX_W+1)'(1);
    msb  = |(x & top);
    lsb  = x[0];
    nr   = x;
    ncf  = cf;
    unique case (m)
      MODE_LSL: begin
        nr  = x << 1;
        ncf = msb;
      end
      MODE_LSR: begin
        nr  = x >> 1;
        ncf = lsb;
      end
      MODE_ASR: begin
        nr  = (x >> 1) | (msb ? top : '0);
        ncf = lsb;
      end
      MODE_ROL: begin
        nr  = (x << 1) | {{MAX_W{1'b0}}, msb};
        ncf = msb;
      end
      MODE_ROR: begin
        nr  = (x >> 1) | (lsb ? top : '0);
        ncf = lsb;
      end
      MODE_RCL: begin
        nr  = (x << 1) | {{MAX_W{1'b0}}, cf};
        ncf = msb;
      end
      MODE_RCR: begin
        nr  = (x >> 1) | (cf ? top : '0);
        ncf = lsb;
      end
      MODE_PASS: begin
        nr  = x;
        ncf = cf;
      end
    endcase
    return (nr & mask) | (ncf ? (top << 1) : '0);
  endfunction

endpackage

// File: rtl/transfer_and_nbit.sv
// Enable-AND gate driving an N-bit value onto the S-bus.
// Output is all zeros whenever the enable is low.
module transfer_and_nbit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data
);

  assign o_data = i_data & {WIDTH{i_en}};

endmodule

// File: rtl/multicycle_shifter.sv
// Iterative shifter: one bit per clock, start/busy/done
// handshake, carry flag and gated S-bus output.
module multicycle_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             cin,
  input  logic [WIDTH-1:0] A_bus,
  input  logic             SHS,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] shifter_out,
  output logic             Cf
);

  state_e           r_state;
  state_e           w_nxt;
  mode_e            r_mode;
  mode_e            w_mode;
  logic [AMT_W-1:0] r_cnt;
  logic [AMT_W-1:0] w_amt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_nr;
  logic             r_cf;
  logic             w_ncf;
  logic             w_accept;
  logic             w_direct;

  assign w_mode   = mode_e'(mode);
  assign w_amt    = (amount > AMT_W'(WIDTH)) ?
                    AMT_W'(WIDTH) : amount;
  assign w_accept = start && (r_state != ST_SHIFT);
  assign w_direct = (w_amt == '0) ||
                    (w_mode == MODE_PASS);

  assign {w_ncf, w_nr} = (WIDTH+1)'(shift_step(
    r_mode, MAX_W'(r_result), r_cf, WIDTH));

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start)
          w_nxt = w_direct ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_cnt == AMT_W'(1))
          w_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start)
          w_nxt = w_direct ? ST_DONE : ST_SHIFT;
        else
          w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_nxt;
  end

  // Operands are captured only at accept; SHIFT ignores the inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_cf     <= 1'b0;
      r_cnt    <= '0;
      r_mode   <= MODE_LSL;
    end else if (w_accept) begin
      r_result <= A_bus;
      r_cf     <= cin;
      r_cnt    <= w_amt;
      r_mode   <= w_mode;
    end else if (r_state == ST_SHIFT) begin
      r_result <= w_nr;
      r_cf     <= w_ncf;
      r_cnt    <= r_cnt - AMT_W'(1);
    end
  end

  assign busy   = (r_state == ST_SHIFT);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign Cf     = r_cf;

  transfer_and_nbit #(
    .WIDTH (WIDTH)
  ) u_sbus (
    .i_data (r_result),
    .i_en   (SHS),
    .o_data (shifter_out)
  );

endmodule

// File: tb/tb_multicycle_shifter.sv
// Directed bench for multicycle_shifter (WIDTH=16):
// latency, busy length, result/Cf, S-bus gating, reset abort.
module tb_multicycle_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  mode;
  logic [4:0]  amount;
  logic        cin;
  logic [15:0] A_bus;
  logic        SHS;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] shifter_out;
  logic        Cf;

  int n_vec = 0;
  int n_bad = 0;

  multicycle_shifter #(
    .WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .amount      (amount),
    .cin         (cin),
    .A_bus       (A_bus),
    .SHS         (SHS),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .shifter_out (shifter_out),
    .Cf          (Cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic run_op(input string       tag,
                        input logic [2:0]  m,
                        input logic [4:0]  amt,
                        input logic        c,
                        input logic [15:0] a,
                        input int          exp_busy,
                        input logic [15:0] exp_r,
                        input logic        exp_c,
                        input bit          poke);
    int  lat;
    int  nb;
    bit  seen;
    bit  both;
    @(negedge clk);
    mode   = m;
    amount = amt;
    cin    = c;
    A_bus  = a;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A_bus = ~a;
    cin   = ~c;
    mode  = 3'b111;
    lat   = 0;
    nb    = 0;
    seen  = 1'b0;
    both  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy) nb++;
      if (busy && done) both = 1'b1;
      if (done) seen = 1'b1;
      if (poke && i == 0) begin
        start  = 1'b1;
        A_bus  = 16'hFFFF;
        amount = 5'd0;
      end
      if (poke && i == 1) start = 1'b0;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_busy + 1));
    chk({tag, "_busy"}, 32'(nb), 32'(exp_busy));
    chk({tag, "_ovl"}, 32'(both), 32'd0);
    chk({tag, "_res"}, 32'(result), 32'(exp_r));
    chk({tag, "_cf"}, 32'(Cf), 32'(exp_c));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(result), 32'(exp_r));
  endtask

  initial begin
    bit seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = 3'b000;
    amount = 5'd0;
    cin    = 1'b0;
    A_bus  = 16'h0000;
    SHS    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_cf", 32'(Cf), 32'd0);
    chk("rst_sbus", 32'(shifter_out), 32'd0);
    rst_n = 1'b1;

    run_op("lsl1", 3'b000, 5'd1, 1'b0, 16'h8001,
           1, 16'h0002, 1'b1, 1'b0);
    run_op("asr4", 3'b010, 5'd4, 1'b0, 16'h8000,
           4, 16'hF800, 1'b0, 1'b0);
    run_op("ror1", 3'b100, 5'd1, 1'b0, 16'h0001,
           1, 16'h8000, 1'b1, 1'b0);
    run_op("rcl2", 3'b101, 5'd2, 1'b0, 16'h8000,
           2, 16'h0001, 1'b0, 1'b0);
    run_op("lsr0", 3'b001, 5'd0, 1'b1, 16'h1234,
           0, 16'h1234, 1'b1, 1'b0);
    run_op("lsr31", 3'b001, 5'd31, 1'b0, 16'hFFFF,
           16, 16'h0000, 1'b1, 1'b0);
    run_op("asr20", 3'b010, 5'd20, 1'b0, 16'h8000,
           16, 16'hFFFF, 1'b1, 1'b0);
    run_op("rol16", 3'b011, 5'd16, 1'b1, 16'h1234,
           16, 16'h1234, 1'b0, 1'b0);
    run_op("pass5", 3'b111, 5'd5, 1'b1, 16'hABCD,
           0, 16'hABCD, 1'b1, 1'b0);
    run_op("rcr3", 3'b110, 5'd3, 1'b1, 16'h0006,
           3, 16'hA000, 1'b1, 1'b0);
    run_op("poke", 3'b011, 5'd3, 1'b0, 16'h0003,
           3, 16'h0018, 1'b0, 1'b1);

    @(negedge clk);
    SHS = 1'b0;
    #1;
    chk("shs0_out", 32'(shifter_out), 32'h0000);
    chk("shs0_res", 32'(result), 32'h0018);
    SHS = 1'b1;
    #1;
    chk("shs1_out", 32'(shifter_out), 32'h0018);

    @(negedge clk);
    mode   = 3'b000;
    amount = 5'd8;
    cin    = 1'b1;
    A_bus  = 16'h00FF;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res", 32'(result), 32'd0);
    chk("abort_cf", 32'(Cf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
